// File: rtl/exec_mem_unit.sv
// exec_mem_unit: rv32i ALU, 4 KiB byte-enable data BRAM and load extractor.
// Optional DEBUG_PORT_EN drives debug_data from memory; otherwise it reads 0.
module exec_mem_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            alu_ctrl,
  input  logic                  alu_src,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [DATA_WIDTH-1:0] sign_ext,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [3:0]            byte_enb,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [2:0]            func3,
  input  logic                  ld_mode,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_dat,
  input  logic                  ld_enb,
  input  logic [3:0]            ld_byte_enb,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] results,
  output logic                  zero,
  output logic                  res_last_bit,
  output logic [DATA_WIDTH-1:0] mem_wb_data,
  output logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] debug_data
);
  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
  localparam int IW    = ADDR_WIDTH - 2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] op_b;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] alu_d;

  assign op_b  = alu_src ? sign_ext : src2;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_d = '0;
    unique case (alu_ctrl)
      4'b0000: alu_d = src1 + op_b;
      4'b0001: alu_d = src1 - op_b;
      4'b0010: alu_d = src1 & op_b;
      4'b0011: alu_d = src1 | op_b;
      4'b0100: alu_d = src1 ^ op_b;
      4'b0101: alu_d = src1 << shamt;
      4'b0110: alu_d = src1 >> shamt;
      4'b0111: alu_d = $signed(src1) >>> shamt;
      4'b1000: alu_d = {{(DATA_WIDTH-1){1'b0}},
                        $signed(src1) < $signed(op_b)};
      4'b1001: alu_d = {{(DATA_WIDTH-1){1'b0}}, src1 < op_b};
      default: alu_d = '0;
    endcase
  end

  assign results      = alu_d;
  assign zero         = (alu_d == '0);
  assign res_last_bit = alu_d[0];

  logic [IW-1:0]         wr_idx_d;
  logic [DATA_WIDTH-1:0] wr_dat_d;
  logic                  wr_en_d;
  logic [3:0]            wr_be_d;

  always_comb begin
    wr_idx_d = alu_d[ADDR_WIDTH-1:2];
    wr_dat_d = mem_write_data;
    wr_en_d  = mem_write;
    wr_be_d  = byte_enb;
    if (ld_mode) begin
      wr_idx_d = ld_addr[ADDR_WIDTH-1:2];
      wr_dat_d = ld_dat;
      wr_en_d  = ld_enb;
      wr_be_d  = ld_byte_enb;
    end
  end

  // Storage is never cleared; reset only blocks the write at the edge.
  always_ff @(posedge clk) begin
    if (rst && wr_en_d) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be_d[i])
          mem_q[wr_idx_d][8*i +: 8] <= wr_dat_d[8*i +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] r_dat;
  logic [7:0]            bsel;
  logic [15:0]           hsel;
  logic                  b_ok;
  logic                  h_ok;
  logic [DATA_WIDTH-1:0] wb_d;
  logic                  vld_d;

  assign r_dat = mem_read ? mem_q[alu_d[ADDR_WIDTH-1:2]] : '0;

  always_comb begin
    bsel = 8'h00;
    b_ok = 1'b1;
    unique case (byte_enb)
      4'b0001: bsel = r_dat[7:0];
      4'b0010: bsel = r_dat[15:8];
      4'b0100: bsel = r_dat[23:16];
      4'b1000: bsel = r_dat[31:24];
      default: b_ok = 1'b0;
    endcase
    hsel = 16'h0000;
    h_ok = 1'b1;
    unique case (byte_enb)
      4'b0011: hsel = r_dat[15:0];
      4'b1100: hsel = r_dat[31:16];
      default: h_ok = 1'b0;
    endcase
  end

  always_comb begin
    wb_d  = '0;
    vld_d = 1'b0;
    unique case (func3)
      3'b000: begin
        vld_d = b_ok;
        wb_d  = {{24{bsel[7]}}, bsel};
      end
      3'b100: begin
        vld_d = b_ok;
        wb_d  = {24'h0, bsel};
      end
      3'b001: begin
        vld_d = h_ok;
        wb_d  = {{16{hsel[15]}}, hsel};
      end
      3'b101: begin
        vld_d = h_ok;
        wb_d  = {16'h0, hsel};
      end
      3'b010: begin
        vld_d = (byte_enb == 4'b1111);
        wb_d  = r_dat;
      end
      default: vld_d = 1'b0;
    endcase
  end

  assign mem_valid   = rst && vld_d;
  assign mem_wb_data = mem_valid ? wb_d : '0;

`ifdef DEBUG_PORT_EN
  assign debug_data = mem_q[debug_addr[ADDR_WIDTH-1:2]];
`else
  assign debug_data = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{ld_addr[1:0], debug_addr};

endmodule

// File: tb/tb_exec_mem_unit.sv
// Scoreboard bench for exec_mem_unit: directed vectors push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_exec_mem_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alu_ctrl;
  logic        alu_src;
  logic [31:0] src1, src2, sign_ext;
  logic        mem_read, mem_write;
  logic [3:0]  byte_enb;
  logic [31:0] mem_write_data;
  logic [2:0]  func3;
  logic        ld_mode;
  logic [11:0] ld_addr;
  logic [31:0] ld_dat;
  logic        ld_enb;
  logic [3:0]  ld_byte_enb;
  logic [11:0] debug_addr;
  logic [31:0] results;
  logic        zero, res_last_bit;
  logic [31:0] mem_wb_data;
  logic        mem_valid;
  logic [31:0] debug_data;

`ifdef DEBUG_PORT_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  exec_mem_unit dut (
    .clk(clk), .rst(rst),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src),
    .src1(src1), .src2(src2), .sign_ext(sign_ext),
    .mem_read(mem_read), .mem_write(mem_write),
    .byte_enb(byte_enb), .mem_write_data(mem_write_data),
    .func3(func3), .ld_mode(ld_mode), .ld_addr(ld_addr),
    .ld_dat(ld_dat), .ld_enb(ld_enb), .ld_byte_enb(ld_byte_enb),
    .debug_addr(debug_addr), .results(results), .zero(zero),
    .res_last_bit(res_last_bit), .mem_wb_data(mem_wb_data),
    .mem_valid(mem_valid), .debug_data(debug_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] v;
    logic        b;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      case (e.kind)
        0: begin
          cmp({e.nm, ".results"}, results, e.v);
          cmp({e.nm, ".zero"}, {31'b0, zero}, {31'b0, e.v == 0});
          cmp({e.nm, ".lsb"}, {31'b0, res_last_bit}, {31'b0, e.v[0]});
        end
        1: begin
          cmp({e.nm, ".wb"}, mem_wb_data, e.v);
          cmp({e.nm, ".valid"}, {31'b0, mem_valid}, {31'b0, e.b});
        end
        default: cmp({e.nm, ".dbg"}, debug_data, e.v);
      endcase
    end
  end

  task automatic x_alu(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm; e.kind = 0; e.v = v; e.b = 1'b0;
    q.push_back(e);
  endtask

  task automatic x_mem(input string nm, input logic [31:0] v, input logic b);
    exp_t e;
    e.nm = nm; e.kind = 1; e.v = v; e.b = b;
    q.push_back(e);
  endtask

  task automatic x_dbg(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm; e.kind = 2; e.v = DBG ? v : 32'h0;
    e.b = 1'b0;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b);
    alu_ctrl = c; alu_src = 1'b0; src1 = a; src2 = b;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] f3,
                      input logic [3:0] be);
    alu_ctrl = 4'b0000; alu_src = 1'b1; src1 = addr; sign_ext = 32'h0;
    mem_read = 1'b1; func3 = f3; byte_enb = be;
  endtask

  task automatic loader(input logic [11:0] a, input logic [31:0] d);
    ld_mode = 1'b1; ld_enb = 1'b1; ld_addr = a; ld_dat = d;
    ld_byte_enb = 4'hF;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    alu_ctrl = 0; alu_src = 0; src1 = 0; src2 = 0; sign_ext = 0;
    mem_read = 0; mem_write = 0; byte_enb = 0; mem_write_data = 0;
    func3 = 0; ld_mode = 0; ld_addr = 0; ld_dat = 0; ld_enb = 0;
    ld_byte_enb = 0; debug_addr = 0;
    tick();
    // ALU stays alive in reset; loads are forced invalid
    load(32'h0, 3'b010, 4'hF);
    src1 = 3; sign_ext = 4;
    x_alu("rst_add", 32'h7);
    x_mem("rst_load", 32'h0, 1'b0);
    tick();
    rst = 1'b1;
    mem_read = 0;
    tick();

    loader(12'h000, 32'h1);
    loader(12'h004, 32'h2);
    loader(12'h010, 32'h80FF7F01);
    ld_enb = 0; ld_mode = 0;

    load(32'h0, 3'b010, 4'hF); sign_ext = 4;
    x_alu("lw4_addr", 32'h4);
    x_mem("lw4", 32'h2, 1'b1);
    tick();
    load(32'h0, 3'b010, 4'hF);
    x_mem("lw0", 32'h1, 1'b1);
    tick();

    alu(4'b0000, 32'h8, 32'h4);
    mem_read = 0; mem_write = 1; mem_write_data = 32'h3;
    func3 = 3'b010; byte_enb = 4'hF;
    x_alu("st_addr", 32'hC);
    x_mem("st_noread", 32'h0, 1'b1);
    tick();
    mem_write = 0; debug_addr = 12'h00C;
    load(32'hC, 3'b010, 4'hF);
    x_dbg("dbg_c", 32'h3);
    x_mem("lw_c", 32'h3, 1'b1);
    tick();
    mem_write = 1; mem_write_data = 32'h5;
    x_mem("rdw_old", 32'h3, 1'b1);
    tick();
    mem_write = 0;
    x_mem("rdw_new", 32'h5, 1'b1);
    tick();

    mem_read = 0;
    alu(4'b0001, 5, 5);           x_alu("sub", 32'h0);           tick();
    alu(4'b1000, 32'hFFFFFFFF, 1); x_alu("slt", 32'h1);          tick();
    alu(4'b1001, 32'hFFFFFFFF, 1); x_alu("sltu", 32'h0);         tick();
    alu(4'b0111, 32'h80000000, 4); x_alu("sra", 32'hF8000000);   tick();
    alu(4'b0110, 32'h80000000, 32'h24);
    x_alu("srl_b40", 32'h08000000);                             tick();
    alu(4'b0101, 32'h1, 31);      x_alu("sll", 32'h80000000);    tick();
    alu(4'b0010, 32'hF0F0, 32'hFF00); x_alu("and", 32'hF000);    tick();
    alu(4'b0011, 32'hF0F0, 32'hFF00); x_alu("or", 32'hFFF0);     tick();
    alu(4'b0100, 32'hF0F0, 32'hFF00); x_alu("xor", 32'h0FF0);    tick();
    alu(4'b0000, 32'hFFFFFFFF, 1); x_alu("add_wrap", 32'h0);     tick();
    alu(4'b1111, 32'h12, 32'h34); x_alu("illegal_op", 32'h0);    tick();

    load(32'h10, 3'b000, 4'b0100); x_mem("lb2", 32'hFFFFFFFF, 1); tick();
    load(32'h10, 3'b100, 4'b1000); x_mem("lbu3", 32'h80, 1);      tick();
    load(32'h10, 3'b001, 4'b1100); x_mem("lh1", 32'hFFFF80FF, 1); tick();
    load(32'h10, 3'b101, 4'b0011); x_mem("lhu0", 32'h7F01, 1);    tick();
    load(32'h10, 3'b000, 4'b0001); x_mem("lb0", 32'h01, 1);       tick();
    load(32'h10, 3'b000, 4'b0011); x_mem("lb_bad", 32'h0, 0);     tick();
    load(32'h1010, 3'b010, 4'hF);
    x_alu("wrap_addr", 32'h1010);
    x_mem("lw_wrap", 32'h80FF7F01, 1);
    tick();

    alu(4'b0000, 32'h10, 32'h0);
    mem_read = 0; mem_write = 1; mem_write_data = 32'h0000AB00;
    byte_enb = 4'b0010;
    tick();
    mem_write = 0; debug_addr = 12'h010;
    load(32'h10, 3'b010, 4'hF);
    x_mem("part_st", 32'h80FFAB01, 1);
    x_dbg("dbg_10", 32'h80FFAB01);
    tick();
    load(32'h10, 3'b010, 4'b0011); x_mem("lw_bad", 32'h0, 0);     tick();
    load(32'h10, 3'b011, 4'hF);    x_mem("f3_bad", 32'h0, 0);     tick();

    load(32'h10, 3'b010, 4'hF);
    mem_write = 1; mem_write_data = 32'hDEADBEEF;
    rst = 1'b0;
    x_mem("rst_wr", 32'h0, 0);
    tick();
    mem_write = 0;
    ld_mode = 1; ld_enb = 1; ld_addr = 12'h010; ld_dat = 32'h12345678;
    ld_byte_enb = 4'hF;
    tick();
    ld_mode = 0; ld_enb = 0;
    #2 rst = 1'b1;
    x_mem("after_rst", 32'h80FFAB01, 1);
    tick();

    repeat (3) tick();
    if (q.size() != 0) begin
      failures++;
      checks++;
      $display("FAIL drain: got %0d pending, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
